// File: rtl/dmem_access_ctrl_if.sv
// ============================================================================
// Module      : dmem_access_ctrl_if
// Description : Core request/response and RAM port bundle for dmem_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_signed;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_signed,
        input  mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_signed,
        output mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Single-outstanding load/store responder for a word-wide RAM
//               without byte enables; sub-word stores use read-modify-write.
//               Optional: define DMEM_MISALIGN_TRAP_EN to fault misaligned
//               accesses instead of aligning them down.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_ctrl #(
    parameter int ADDR_W = 12
) (
    input  wire                 clk,
    input  wire                 rst_n,
    dmem_access_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;
    localparam logic [1:0] c_SZ_ILL  = 2'b11;

    state_t            r_state;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [31:0]       r_rdword;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;

    logic              w_fault;

    function automatic logic [31:0] f_lane_extract(
        input logic [31:0] i_word,
        input logic [1:0]  i_lane,
        input logic [1:0]  i_size,
        input logic        i_sgn
    );
        logic [7:0]  w_b;
        logic [15:0] w_h;
        logic [31:0] w_res;
        case (i_lane)
            2'd0:    w_b = i_word[7:0];
            2'd1:    w_b = i_word[15:8];
            2'd2:    w_b = i_word[23:16];
            default: w_b = i_word[31:24];
        endcase
        w_h = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            c_SZ_BYTE: w_res = {{24{i_sgn & w_b[7]}}, w_b};
            c_SZ_HALF: w_res = {{16{i_sgn & w_h[15]}}, w_h};
            default:   w_res = i_word;
        endcase
        return w_res;
    endfunction

    function automatic logic [31:0] f_lane_merge(
        input logic [31:0] i_word,
        input logic [31:0] i_wdata,
        input logic [1:0]  i_lane,
        input logic [1:0]  i_size
    );
        logic [31:0] w_res;
        w_res = i_word;
        case (i_size)
            c_SZ_BYTE: begin
                case (i_lane)
                    2'd0:    w_res[7:0]   = i_wdata[7:0];
                    2'd1:    w_res[15:8]  = i_wdata[7:0];
                    2'd2:    w_res[23:16] = i_wdata[7:0];
                    default: w_res[31:24] = i_wdata[7:0];
                endcase
            end
            c_SZ_HALF: begin
                if (i_lane[1]) w_res[31:16] = i_wdata[15:0];
                else           w_res[15:0]  = i_wdata[15:0];
            end
            default: w_res = i_wdata;
        endcase
        return w_res;
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((bus.req_size == c_SZ_HALF) && bus.req_addr[0]) ||
                        ((bus.req_size == c_SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
    assign w_fault    = (bus.req_size == c_SZ_ILL) || w_misalign;
`else
    // Misaligned accesses fall through: lane selection ignores the low bits
    // that would make them misaligned, which aligns them down for free.
    assign w_fault    = (bus.req_size == c_SZ_ILL);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_rdword    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_write  <= bus.req_write;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_size   <= bus.req_size;
                        r_signed <= bus.req_signed;
                        if (w_fault) begin
                            r_state     <= S_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else if (bus.req_write && (bus.req_size == c_SZ_WORD)) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_rdword <= bus.mem_rdata;
                    if (r_write) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= f_lane_extract(bus.mem_rdata, r_addr[1:0], r_size, r_signed);
                    end
                end
                S_WRITE: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                S_RESP, S_ERR: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    // RAM strobes are gated by rst_n so a reset mid-operation cannot write.
    assign bus.mem_en    = rst_n && ((r_state == S_READ) || (r_state == S_WRITE));
    assign bus.mem_we    = rst_n && (r_state == S_WRITE);
    assign bus.mem_addr  = r_addr[ADDR_W-1:2];
    assign bus.mem_wdata = f_lane_merge(r_rdword, r_wdata, r_addr[1:0], r_size);

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Vector table plus corner sequences for dmem_access_ctrl,
//               responses checked against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

    localparam int ADDR_W = 12;
    localparam int NWORDS = 1 << (ADDR_W - 2);
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM model: one-cycle read latency, preload port for setup
    logic [31:0]       ram [NWORDS];
    logic              pl_en   = 1'b0;
    logic [ADDR_W-3:0] pl_addr = '0;
    logic [31:0]       pl_data = '0;
    logic [31:0]       r_rd    = '0;
    assign bus.mem_rdata = r_rd;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            r_rd <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        int          id;
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [1:0]        size;
        logic              sgn;
        logic [31:0]       rdata;
        logic              err;
        int                lat;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (bus.rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected no response", cyc);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("rsp%0d_cycle", e.id), cyc, e.due);
                chk($sformatf("rsp%0d_rdata", e.id), bus.rsp_rdata, e.rdata);
                chk($sformatf("rsp%0d_err", e.id), 32'(bus.rsp_err), 32'(e.err));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic preload(input logic [ADDR_W-3:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic drive_req(input int id, input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wd, input logic [1:0] sz, input logic sgn,
                             input logic push, input logic [31:0] er, input logic ee,
                             input int lat, output int c);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req%0d_ready_timeout: got req_ready=%b expected 1", id, bus.req_ready);
        end
        c              = cyc;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_size   = sz;
        bus.req_signed = sgn;
        if (push) sbq.push_back('{id, cyc + lat, er, ee});
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic add(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sgn, input logic [31:0] er,
                       input logic ee, input int lat);
        vecs.push_back('{wr, addr, wd, sz, sgn, er, ee, lat});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        int c2;
        int we_seen;
        int rv_seen;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        rst_n          = 1'b0;
        tick();
        tick();

        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);

        preload(10'd1, 32'h80FF7F01);
        preload(10'd2, 32'h55667788);
        preload(10'd3, 32'h00000000);
        rst_n = 1'b1;
        tick();

        //   wr    addr     wdata         sz     sgn   rdata          err   lat
        add(1'b0, 12'h005, 32'h0,        2'b00, 1'b1, 32'h0000007F, 1'b0, 3);
        add(1'b0, 12'h007, 32'h0,        2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 3);
        add(1'b0, 12'h007, 32'h0,        2'b00, 1'b0, 32'h00000080, 1'b0, 3);
        add(1'b0, 12'h006, 32'h0,        2'b00, 1'b1, 32'hFFFFFFFF, 1'b0, 3);
        add(1'b0, 12'h004, 32'h0,        2'b00, 1'b0, 32'h00000001, 1'b0, 3);
        add(1'b0, 12'h006, 32'h0,        2'b01, 1'b0, 32'h000080FF, 1'b0, 3);
        add(1'b0, 12'h006, 32'h0,        2'b01, 1'b1, 32'hFFFF80FF, 1'b0, 3);
        add(1'b0, 12'h004, 32'h0,        2'b01, 1'b1, 32'h00007F01, 1'b0, 3);
        add(1'b0, 12'h004, 32'h0,        2'b10, 1'b0, 32'h80FF7F01, 1'b0, 3);
        add(1'b0, 12'h005, 32'h0,        2'b01, 1'b0, TRAP ? 32'h0 : 32'h00007F01, TRAP, TRAP ? 1 : 3);
        add(1'b0, 12'h004, 32'h0,        2'b11, 1'b0, 32'h0,        1'b1, 1);
        add(1'b1, 12'h004, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        1'b1, 1);
        add(1'b0, 12'h006, 32'h0,        2'b10, 1'b0, TRAP ? 32'h0 : 32'h80FF7F01, TRAP, TRAP ? 1 : 3);
        add(1'b1, 12'h00A, 32'hAAAA1234, 2'b01, 1'b0, 32'h0,        1'b0, 4);
        add(1'b0, 12'h008, 32'h0,        2'b10, 1'b0, 32'h12347788, 1'b0, 3);
        add(1'b1, 12'h009, 32'h000000CC, 2'b00, 1'b0, 32'h0,        1'b0, 4);
        add(1'b0, 12'h009, 32'h0,        2'b00, 1'b1, 32'hFFFFFFCC, 1'b0, 3);
        add(1'b1, 12'h00C, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0, 2);
        add(1'b0, 12'h00C, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 3);
        add(1'b1, 12'h00D, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        TRAP, TRAP ? 1 : 2);
        add(1'b0, 12'h00C, 32'h0,        2'b10, 1'b0, TRAP ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0, 3);
        add(1'b1, 12'h00B, 32'h0000BEEF, 2'b01, 1'b0, 32'h0,        TRAP, TRAP ? 1 : 4);
        add(1'b0, 12'h008, 32'h0,        2'b10, 1'b0, TRAP ? 32'h1234CC88 : 32'hBEEFCC88, 1'b0, 3);
        add(1'b0, 12'h004, 32'h0,        2'b10, 1'b0, 32'h80FF7F01, 1'b0, 3);

        foreach (vecs[i]) begin
            drive_req(i, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sgn,
                      1'b1, vecs[i].rdata, vecs[i].err, vecs[i].lat, c);
        end
        drain();

        // Byte store read-modify-write strobe timing
        drive_req(100, 1'b1, 12'h006, 32'h12345678, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 4, c);
        chk("A_rd_en",   32'(bus.mem_en),   32'd1);
        chk("A_rd_we",   32'(bus.mem_we),   32'd0);
        chk("A_rd_addr", 32'(bus.mem_addr), 32'd1);
        tick();
        chk("A_wait_en", 32'(bus.mem_en),   32'd0);
        tick();
        chk("A_wr_en",    32'(bus.mem_en),   32'd1);
        chk("A_wr_we",    32'(bus.mem_we),   32'd1);
        chk("A_wr_addr",  32'(bus.mem_addr), 32'd1);
        chk("A_wr_wdata", bus.mem_wdata,     32'h80787F01);
        drain();
        chk("A_ram", ram[1], 32'h80787F01);

        // Word store skips the read, then back-to-back acceptance
        drive_req(101, 1'b1, 12'h004, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, 2, c);
        chk("B_wr_en",    32'(bus.mem_en), 32'd1);
        chk("B_wr_we",    32'(bus.mem_we), 32'd1);
        chk("B_wr_wdata", bus.mem_wdata,   32'hDEADBEEF);
        tick();
        tick();
        chk("B_ready_after_rsp", 32'(bus.req_ready), 32'd1);
        drive_req(102, 1'b0, 12'h004, 32'h0, 2'b10, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 3, c2);
        chk("B_back_to_back", 32'(c2), 32'(c + 3));
        drain();

        // Misaligned halfword load: trap without RAM access, or aligned down
        drive_req(103, 1'b0, 12'h005, 32'h0, 2'b01, 1'b0, 1'b1,
                  TRAP ? 32'h0 : 32'h0000BEEF, TRAP, TRAP ? 1 : 3, c);
        chk("C_mem_en", 32'(bus.mem_en), TRAP ? 32'd0 : 32'd1);
        drain();

        // Reset during WAIT of a sub-word store aborts it
        preload(10'd1, 32'h80FF7F01);
        drive_req(104, 1'b1, 12'h006, 32'h12345678, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 0, c);
        chk("D_read_en", 32'(bus.mem_en), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("D_rst_en", 32'(bus.mem_en), 32'd0);
        chk("D_rst_we", 32'(bus.mem_we), 32'd0);
        tick();
        chk("D_ready",     32'(bus.req_ready), 32'd1);
        chk("D_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n   = 1'b1;
        we_seen = 0;
        rv_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.mem_we === 1'b1)    we_seen++;
            if (bus.rsp_valid === 1'b1) rv_seen++;
        end
        chk("D_no_we",  32'(we_seen), 32'd0);
        chk("D_no_rsp", 32'(rv_seen), 32'd0);
        chk("D_ram",    ram[1],       32'h80FF7F01);

        // Reset while READ drives mem_en low before the edge
        drive_req(105, 1'b0, 12'h004, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 0, c);
        chk("E_read_en", 32'(bus.mem_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("E_rst_forces_en", 32'(bus.mem_en), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("E_ready", 32'(bus.req_ready), 32'd1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Memory-side responder for core loads and stores. It services one request at a time and drives a single-port, word-wide, synchronous data RAM that has no byte enables. Sub-word stores run as read-modify-write. Load data is returned lane-extracted and sign/zero-extended.

Parameters:
ADDR_W, 12, byte-address width; the RAM holds 2^(ADDR_W-2) 32-bit words.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data; byte in [7:0], halfword in [15:0]
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  sign-extend load result
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  access fault; valid with rsp_valid
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write strobe
mem_addr  out  ADDR_W-2  RAM word address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid the cycle after a read strobe

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- On any rising edge with rst_n=0:
  - state goes to IDLE; rsp_valid, rsp_err and rsp_rdata go to 0; latched request and read-word registers clear.
  - From that edge onward: req_ready=1, mem_en=0, mem_we=0.
- While rst_n=0, mem_en and mem_we are forced to 0 combinationally. A reset mid-operation therefore aborts with no RAM write and no response.
- Handshake: a request is accepted when req_valid & req_ready at a rising edge (cycle N). On acceptance, addr, wdata, size, signed and write are latched. Inputs are ignored at all other times. Responses have no backpressure; the core must wait for rsp_valid.
- mem_en, mem_we, mem_addr and mem_wdata decode combinationally from state and latched registers. rsp_* outputs are registered.
- mem_addr = latched addr[ADDR_W-1:2].
- State machine (IDLE, READ, WAIT, WRITE, RESP, ERR):
  - IDLE: req_ready=1. On acceptance: illegal or misaligned request goes to ERR; word store goes to WRITE; every other request goes to READ.
  - READ: mem_en=1, mem_we=0. Next state is WAIT.
  - WAIT: mem_rdata is captured into the read-word register. Store goes to WRITE; load goes to RESP, with rsp_rdata loaded on this edge.
  - WRITE: mem_en=1, mem_we=1. mem_wdata is either req_wdata (word store) or the read word with the addressed lane(s) replaced. Byte lane = addr[1:0]; halfword lane = addr[1]. Next state is RESP.
  - RESP: rsp_valid=1, rsp_err=0. Next state is IDLE.
  - ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0. Next state is IDLE; no memory access.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1]; word passes through unchanged.
  - req_signed=1 replicates bit 7 (byte) or bit 15 (halfword) into the upper bits; otherwise the upper bits are zero-filled.
- Latency (rsp_valid cycle): load N+3; sub-word store N+4; word store N+2; error N+1. req_ready returns high the cycle after RESP/ERR, so back-to-back requests are possible.
- Misaligned = halfword with addr[0]=1, or word with addr[1:0]≠0. size=11 is always illegal and goes to ERR.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: misaligned requests go to ERR as described above.
- Undefined: misaligned halfword/word requests are silently aligned down (addr[0], or addr[1:0], treated as 0) and executed normally. rsp_err is 1 only for size=11.

Test Plan:
1. RAM word 0x004 = 0x80FF7F01.
   - Load byte, signed, addr 0x005 → rsp_valid at N+3, rsp_rdata=0x0000007F.
   - Load byte, signed, addr 0x007 → rsp_rdata=0xFFFFFF80.
   - Load byte, unsigned, addr 0x007 → rsp_rdata=0x00000080.
2. Same word, halfword at addr 0x006:
   - unsigned → rsp_rdata=0x000080FF.
   - signed → rsp_rdata=0xFFFF80FF.
3. Byte store, addr 0x006, wdata 0x12345678:
   - read strobe at N+1.
   - mem_we=1 with mem_wdata=0x80787F01 and mem_addr=1 at N+3.
   - rsp_valid at N+4 with rsp_rdata=0.
4. Word store, addr 0x004, wdata 0xDEADBEEF:
   - no read strobe.
   - mem_we=1 at N+1.
   - rsp_valid at N+2.
   - Issue a second request the cycle after the response → accepted immediately.
5. Halfword load, addr 0x005:
   - With the macro: rsp_err=1 at N+1, no mem_en.
   - Without the macro: executes as addr 0x004, rsp_rdata=0x00007F01.
   - size=11 → rsp_err=1 in both builds.
6. Sub-word store with rst_n=0 during WAIT:
   - mem_we never asserts.
   - rsp_valid stays 0.
   - req_ready=1 after the reset edge; RAM word unchanged.
